// File: rtl/spi_deserializer.sv
// SPI receive endpoint. It oversamples SPI_clk, CS and DataBit into the clk domain
// and rebuilds WIDTH-bit words, MSB first.
// Good frames update Data_Out and pulse valid.
// Frames with the wrong bit count pulse frame_err.
module spi_deserializer #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SPI_clk,
  input  logic             CS,
  input  logic             DataBit,
  output logic [WIDTH-1:0] Data_Out,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_OVER = CW'(WIDTH + 1);

  // CHECK is the final cycle of a frame.
  // The frame is judged there, after any last shift has landed.
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, din_sync, settle;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, din_s;
  logic                   sck_rise, cs_fall, cs_rise;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [WIDTH-1:0]       data_d;
  logic                   valid_d, err_d;
  logic                   armed_q, armed_d;

  // Synchronizer chains.
  // settle fills with ones as the reset values are flushed out of the chains.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      din_sync <= '0;
      settle   <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SPI_clk};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
      din_sync <= {din_sync[SYNC_STAGES-2:0], DataBit};
      settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign busy     = (state_q != IDLE);

  // Frame state, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shreg_q   <= '0;
      Data_Out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      Data_Out  <= data_d;
      valid     <= valid_d;
      frame_err <= err_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state logic.
  // The receiver is armed only after a genuine high CS has been synchronized.
  // A CS line that is already low when reset is released cannot start a frame.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    data_d  = Data_Out;
    valid_d = 1'b0;
    err_d   = 1'b0;
    armed_d = armed_q | (settle[SYNC_STAGES-1] & cs_s);
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = RECV;
          count_d = '0;
        end
      end
      RECV: begin
        if (sck_rise) begin
          shreg_d = {shreg_q[WIDTH-2:0], din_s};
          if (count_q != COUNT_OVER) begin
            count_d = count_q + CW'(1);
          end
        end
        if (cs_rise) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (count_q == COUNT_FULL) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed testbench for spi_deserializer.
// It drives SPI frames with four clk cycles per SPI_clk phase.
// A monitor counts the valid and frame_err pulses.
module tb_spi_deserializer;

  localparam int WIDTH = 32;
  localparam int HALF  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             SPI_clk;
  logic             CS;
  logic             DataBit;
  logic [WIDTH-1:0] Data_Out;
  logic             valid;
  logic             frame_err;
  logic             busy;

  int               compared   = 0;
  int               mismatched = 0;
  int               valid_pulses = 0;
  int               err_pulses   = 0;
  int               both_high    = 0;
  logic [WIDTH-1:0] rx_words[$];

  spi_deserializer #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SPI_clk(SPI_clk), .CS(CS), .DataBit(DataBit),
    .Data_Out(Data_Out), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Pulse monitor. It samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_pulses++;
      rx_words.push_back(Data_Out);
    end
    if (frame_err) err_pulses++;
    if (valid && frame_err) both_high++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    DataBit = b;
    repeat (HALF) @(negedge clk);
    SPI_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    SPI_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(word[i]);
  endtask

  // Drops CS, sends n bits, then waits out the last SPI_clk low phase. CS stays low.
  task automatic frame_body(input logic [63:0] word, input int n);
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(word, n);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic full_frame(input logic [63:0] word, input int n);
    frame_body(word, n);
    CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; SPI_clk = 1'b0; CS = 1'b1; DataBit = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", Data_Out, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_err", {31'b0, frame_err}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Normal frame with the exact end-of-frame latency.
    frame_body(64'hA5C30F96, 32);
    check("normal_busy_in_frame", {31'b0, busy}, 32'h1);
    CS = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("normal_valid_early", {31'b0, valid}, 32'h0);
    check("normal_busy_before", {31'b0, busy}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("normal_valid", {31'b0, valid}, 32'h1);
    check("normal_err", {31'b0, frame_err}, 32'h0);
    check("normal_busy_after", {31'b0, busy}, 32'h0);
    check("normal_data", Data_Out, 32'hA5C30F96);
    repeat (5) @(negedge clk);
    check("normal_valid_count", valid_pulses, 1);
    check("normal_err_count", err_pulses, 0);

    // Short frame: the top 31 bits of 0x12345678.
    full_frame(64'(32'h12345678 >> 1), 31);
    check("short_err_count", err_pulses, 1);
    check("short_valid_count", valid_pulses, 1);
    check("short_data_hold", Data_Out, 32'hA5C30F96);

    // Overrun frame with 33 clocks.
    full_frame({31'b0, 1'b1, 32'h5A5A5A5A}, 33);
    check("over_err_count", err_pulses, 2);
    check("over_valid_count", valid_pulses, 1);
    check("over_data_hold", Data_Out, 32'hA5C30F96);

    // Idle noise with CS high, followed by a good frame.
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (HALF) @(negedge clk);
    check("noise_valid_count", valid_pulses, 1);
    check("noise_err_count", err_pulses, 2);
    check("noise_busy", {31'b0, busy}, 32'h0);
    full_frame(64'h0000FFFF, 32);
    check("after_noise_data", Data_Out, 32'h0000FFFF);
    check("after_noise_valid_count", valid_pulses, 2);

    // Reset after 16 bits, then finish the frame.
    frame_body(64'hDEAD, 16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_bits(64'hBEEF, 16);
    repeat (HALF) @(negedge clk);
    check("midrst_busy_in_frame", {31'b0, busy}, 32'h0);
    CS = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_valid_count", valid_pulses, 2);
    check("midrst_err_count", err_pulses, 2);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_data", Data_Out, 32'h0);
    full_frame(64'h00000001, 32);
    check("midrst_next_valid_count", valid_pulses, 3);
    check("midrst_next_data", Data_Out, 32'h00000001);

    // Back-to-back frames separated by the minimum CS-high gap.
    frame_body(64'hFFFFFFFF, 32);
    CS = 1'b1;
    repeat (3) @(negedge clk);
    full_frame(64'h80000001, 32);
    check("b2b_valid_count", valid_pulses, 5);
    check("b2b_err_count", err_pulses, 2);
    check("b2b_word0", rx_words[3], 32'hFFFFFFFF);
    check("b2b_word1", rx_words[4], 32'h80000001);
    check("never_both_high", both_high, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
